// File: rtl/fix_tx_framer.sv
//======================================================================
// Module   : fix_tx_framer
// Brief    : Store-and-forward FIX framer. Sums body bytes, appends the
//            "10=NNN<DELIM>" trailer and releases only committed messages.
//            Optional header check enabled by defining FIX_TX_HDR_CHECK_EN.
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

module fix_tx_framer #(
    parameter int         DEPTH = 256,
    parameter logic [7:0] DELIM = 8'h7C
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [31:0] msg_count,
    output logic [31:0] overflow_count,
    output logic [31:0] bad_hdr_count
);

    localparam int              c_AW         = $clog2(DEPTH);
    localparam int              c_PW         = c_AW + 1;
    localparam logic [c_PW-1:0] c_DEPTH      = c_PW'(DEPTH);
    localparam logic [c_PW-1:0] c_PTR_ONE    = c_PW'(1);
    localparam logic [c_PW-1:0] c_TRAIL_ROOM = c_PW'(8);
    localparam logic [2:0]      c_TRAIL_LAST = 3'd6;
    localparam logic [7:0]      c_ASCII_0    = 8'h30;
    localparam logic [7:0]      c_ASCII_1    = 8'h31;
    localparam logic [7:0]      c_ASCII_EQ   = 8'h3D;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_BODY  = 2'd1;
    localparam logic [1:0] W_TRAIL = 2'd2;
    localparam logic [1:0] W_DROP  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_cptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_PW-1:0] w_used;
    logic [c_PW-1:0] w_free;
    logic [7:0]      r_sum;
    logic [2:0]      r_tcnt;
    logic [31:0]     r_msg_count;
    logic [31:0]     r_overflow_count;
    logic [8:0]      r_mem [DEPTH];

    logic            w_in_open;
    logic            w_accept;
    logic            w_ovf_evt;
    logic            w_hdr_evt;
    logic            w_drop_evt;
    logic            w_wr_en;
    logic            w_rewind;
    logic            w_commit;
    logic [8:0]      w_wr_word;
    logic [8:0]      w_rd_word;
    logic [7:0]      w_hund;
    logic [7:0]      w_rem;
    logic [7:0]      w_tens;
    logic [7:0]      w_units;
    logic [7:0]      w_trail_byte;

    // Occupancy counts speculative bytes too, so a message never overruns unread data.
    assign w_used     = r_wptr - r_rptr;
    assign w_free     = c_DEPTH - w_used;
    assign w_in_open  = (r_state == W_IDLE) || (r_state == W_BODY);
    assign w_accept   = in_valid && w_in_open;
    assign w_ovf_evt  = w_accept && (in_last ? (w_free < c_TRAIL_ROOM) : (w_free == '0));
    assign w_drop_evt = w_ovf_evt || w_hdr_evt;

`ifdef FIX_TX_HDR_CHECK_EN
    localparam logic [7:0] c_ASCII_8 = 8'h38;

    logic        r_hdr_second;
    logic [31:0] r_bad_hdr_count;

    assign w_hdr_evt = w_accept && !w_ovf_evt &&
                       (((r_state == W_IDLE) && (in_data != c_ASCII_8)) ||
                        ((r_state == W_BODY) && r_hdr_second && (in_data != c_ASCII_EQ)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hdr_second    <= 1'b0;
            r_bad_hdr_count <= 32'd0;
        end else begin
            if (w_accept) begin
                r_hdr_second <= (r_state == W_IDLE);
            end
            if (w_hdr_evt) begin
                r_bad_hdr_count <= r_bad_hdr_count + 32'd1;
            end
        end
    end

    assign bad_hdr_count = r_bad_hdr_count;
`else
    assign w_hdr_evt     = 1'b0;
    assign bad_hdr_count = 32'd0;
`endif

    // Decimal digits of the checksum for the trailer.
    assign w_hund  = (r_sum >= 8'd200) ? 8'd2 : ((r_sum >= 8'd100) ? 8'd1 : 8'd0);
    assign w_rem   = r_sum - (w_hund * 8'd100);
    assign w_tens  = w_rem / 8'd10;
    assign w_units = w_rem - (w_tens * 8'd10);

    always_comb begin
        w_trail_byte = DELIM;
        case (r_tcnt)
            3'd0:    w_trail_byte = c_ASCII_1;
            3'd1:    w_trail_byte = c_ASCII_0;
            3'd2:    w_trail_byte = c_ASCII_EQ;
            3'd3:    w_trail_byte = c_ASCII_0 + w_hund;
            3'd4:    w_trail_byte = c_ASCII_0 + w_tens;
            3'd5:    w_trail_byte = c_ASCII_0 + w_units;
            default: w_trail_byte = DELIM;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= W_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            W_IDLE, W_BODY: begin
                if (w_accept) begin
                    if (w_drop_evt) begin
                        w_next_state = in_last ? W_IDLE : W_DROP;
                    end else if (in_last) begin
                        w_next_state = W_TRAIL;
                    end else begin
                        w_next_state = W_BODY;
                    end
                end
            end
            W_TRAIL: begin
                if (r_tcnt == c_TRAIL_LAST) begin
                    w_next_state = W_IDLE;
                end
            end
            W_DROP: begin
                if (in_valid && in_last) begin
                    w_next_state = W_IDLE;
                end
            end
            default: w_next_state = W_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = w_in_open;
        w_wr_en   = 1'b0;
        w_wr_word = {1'b0, in_data};
        w_rewind  = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            W_IDLE, W_BODY: begin
                w_wr_en  = w_accept && !w_drop_evt;
                w_rewind = w_drop_evt;
            end
            W_TRAIL: begin
                w_wr_en   = 1'b1;
                w_wr_word = {(r_tcnt == c_TRAIL_LAST), w_trail_byte};
                w_commit  = (r_tcnt == c_TRAIL_LAST);
            end
            W_DROP: begin
                w_rewind = 1'b1;
            end
            default: begin
                w_wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr           <= '0;
            r_cptr           <= '0;
            r_rptr           <= '0;
            r_sum            <= 8'd0;
            r_tcnt           <= 3'd0;
            r_msg_count      <= 32'd0;
            r_overflow_count <= 32'd0;
        end else begin
            if (w_rewind) begin
                r_wptr <= r_cptr;
            end else if (w_wr_en) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_commit) begin
                r_cptr      <= r_wptr + c_PTR_ONE;
                r_msg_count <= r_msg_count + 32'd1;
            end
            if (out_valid && out_ready) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            if (w_accept && !w_drop_evt) begin
                r_sum <= (r_state == W_IDLE) ? in_data : (r_sum + in_data);
            end
            r_tcnt <= ((r_state == W_TRAIL) && (r_tcnt != c_TRAIL_LAST)) ? (r_tcnt + 3'd1) : 3'd0;
            if (w_ovf_evt) begin
                r_overflow_count <= r_overflow_count + 32'd1;
            end
        end
    end

    // Storage is not reset; pointer reset alone makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[c_AW-1:0]] <= w_wr_word;
        end
    end

    assign w_rd_word      = r_mem[r_rptr[c_AW-1:0]];
    assign out_valid      = (r_rptr != r_cptr);
    assign out_data       = w_rd_word[7:0];
    assign out_last       = out_valid && w_rd_word[8];
    assign msg_count      = r_msg_count;
    assign overflow_count = r_overflow_count;

endmodule

`default_nettype wire

// File: doc/fix_tx_framer.md
Name: fix_tx_framer

Overview:
Store-and-forward framer directly downstream of the FIX order encoder. It accepts the encoder's body byte stream and computes the true FIX checksum, which is the sum of all body bytes mod 256. It appends the "10=NNN<DELIM>" trailer and releases only complete, committed messages to the network MAC through a ready/valid byte stream. Messages that overflow the buffer are dropped whole, never partially.

Parameters:
DEPTH, 256, FIFO depth in bytes; power of 2, minimum 16.
DELIM, 8'h7C, field delimiter byte used in the trailer ("|"; 8'h01 for wire SOH).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_data  in  8  body byte from encoder
in_valid  in  1  in_data valid this cycle
in_last  in  1  qualifies final body byte of message
in_ready  out  1  framer accepting body bytes
out_data  out  8  framed byte to MAC
out_valid  out  1  out_data valid
out_last  out  1  final byte (trailer delimiter) of message
out_ready  in  1  MAC accepts byte
msg_count  out  32  messages committed
overflow_count  out  32  messages dropped for lack of space
bad_hdr_count  out  32  messages dropped by header check (optional feature)

Behaviour:
- Reset: clk/rstn as stated; reset is asynchronous, active-low. All pointers 0, write state W_IDLE, checksum 0, all counters 0. out_valid=0, out_last=0, in_ready=1.
- Memory: DEPTH x 9 bits, holding data plus last flag. Pointers are log2(DEPTH)+1 bits wide: wptr (speculative write), cptr (committed), rptr (read). free = DEPTH - (wptr - rptr).
- in_ready = (state==W_IDLE || state==W_BODY). Bytes presented while in_ready=0 are ignored and not counted. The encoder has no backpressure, so it must space messages by at least 8 cycles.
- Write FSM:
  - W_IDLE: on in_valid, write byte, sum<=in_data, go W_BODY. If in_last is also set, go W_TRAIL instead.
  - W_BODY: each in_valid writes a byte and does sum<=sum+in_data (8-bit wrap). in_last goes to W_TRAIL.
  - W_TRAIL: 7 consecutive cycles write "1","0","=",H,T,U,DELIM. H/T/U are ASCII decimal digits of sum (H = sum>=200?2:sum>=100?1:0, etc.). DELIM is written with last=1. On that write, cptr<=wptr+1 and msg_count++, then return to W_IDLE.
  - W_DROP: wptr<=cptr, discard input until an in_valid&&in_last byte, then go W_IDLE.
- Overflow: a body byte arriving with free==0, or in_last arriving with free<8 (byte plus trailer), triggers overflow_count++ and entry to W_DROP. If that byte had in_last, return directly to W_IDLE after rewind.
- Read side (show-ahead): out_valid=(rptr!=cptr), out_data/out_last=mem[rptr]. rptr advances on out_valid&&out_ready. The reader never sees uncommitted bytes.
- Latency: in_last byte accepted at edge N; trailer written at edges N+1..N+7; out_valid high after edge N+7 if the FIFO was empty.
- Simultaneous commit and read are legal. A write and a read in the same cycle update free consistently.
- Reset mid-message discards all FIFO contents; no partial message is emitted after reset.
- Counters wrap at 2^32.

Optional Feature:
FIX_TX_HDR_CHECK_EN:
- Defined: the first two body bytes must be "8" and "=". On mismatch at either byte, bad_hdr_count++ and the FSM enters W_DROP at that byte (rewind, discard through in_last).
- Undefined: no header check; bad_hdr_count is tied to 0.

Test Plan:
1. Body "8=FIX|" (38 3D 46 49 58 7C, last on 7C), out_ready=1 -> out stream "8=FIX|10=216|", out_last only on final "|", msg_count=1, out_valid rises 7 cycles after in_last edge.
2. Two messages back-to-back, 8-cycle gap, out_ready toggling 1/0 every cycle -> both framed messages emitted intact and in order, msg_count=2, no byte repeated or lost.
3. DEPTH=16, 12-byte body, out_ready=0 -> overflow_count=1, out_valid stays 0, msg_count=0. A following 6-byte message then frames correctly.
4. Body summing to exactly 256k+5 (e.g. "8=A|" plus padding) -> trailer digits "005"; body summing to 0xFF mod 256 -> "255".
5. With FIX_TX_HDR_CHECK_EN, body "9=X|" -> bad_hdr_count=1, nothing output. Without the macro, the same body is framed as "9=X|10=NNN|" and bad_hdr_count=0.
6. Assert rstn low mid-output of message 1 with message 2 committed behind it -> after release out_valid=0, all counters 0, next message frames normally.
